// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit id codes, length width and input port state encoding
package noc_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } port_state_t;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous first-word-fall-through flit FIFO
module flit_fifo #(
    parameter int WIDTH  = 35,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - NoC router input buffer with packet framing and arbiter request
module input_port_buffer
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam int ENTRY_W = DATA_W + 3;

    logic [ENTRY_W-1:0] head;
    logic [2:0]         head_id;
    logic [DATA_W-1:0]  head_data;
    logic               full;
    logic               empty;
    logic               pop;
    logic               drop;
    logic               xfer;
    port_state_t        state;
    logic [LEN_W-1:0]   length_q;

    flit_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_flit_id, in_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head_id   = head[ENTRY_W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    // Anything other than a header at the head while idle is an orphan and is dropped.
    always_comb begin
        drop = 1'b0;
        xfer = 1'b0;
        if (!empty) begin
            case (state)
                IDLE:      drop = (head_id != FLIT_HEADER);
                REQ, XFER: xfer = grant;
                default:   drop = 1'b0;
            endcase
        end
        pop = drop || xfer;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            length_q <= '0;
        end else begin
            case (state)
                IDLE: if (!empty && head_id == FLIT_HEADER) state <= REQ;
                REQ: begin
                    if (xfer) begin
                        length_q <= head_data[LEN_W-1:0];
                        state    <= XFER;
                    end
                end
                XFER: if (xfer && head_id == FLIT_TAIL) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = !full;
    assign req       = (state != IDLE);
    assign flit_id   = empty ? 3'b000 : head_id;
    assign length    = (!empty && head_id == FLIT_HEADER) ? head_data[LEN_W-1:0] : length_q;
    assign out_valid = xfer;
    assign out_data  = head_data;
    assign err       = drop;

endmodule
